// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO family.
package axis_pkg;

    // Controller mode: normal store-and-forward, or cut-through drain of an
    // oversize packet that can never be held whole.
    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } fifo_state_t;

    // Pointer width: one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Width of one stored beat: tlast plus 8*bytes of tdata.
    function automatic int word_width(input int bytes);
        return 8 * bytes + 1;
    endfunction

    // Storage word for the default single-byte stream. Modules built for
    // other widths declare the same {tlast, tdata} layout locally from
    // their own AXIS_BYTES.
    localparam int AXIS_BYTES_DEFAULT = 1;

    typedef struct packed {
        logic                              tlast;
        logic [8*AXIS_BYTES_DEFAULT-1:0]   tdata;
    } axis_word_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sdp_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     ren,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Synchronous read port; rdata holds when not reading.
    always_ff @(posedge clk) begin
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet buffer with oversize-packet drain.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   NORMAL | only beats of fully written packets are read out
//   DRAIN  | buffer filled by one packet; forward its beats cut-through
//          | until its tlast beat leaves the master port
//
// Pointers: wr_ptr (next write), rd_ptr (next beat to leave the master port,
// frees storage), raddr_ptr (next RAM read into the output skid), commit_ptr
// (wr_ptr just past the most recent tlast). Storage is freed only on pop, so
// beats sitting in the skid still count toward occupancy.
module axis_packet_fifo
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES = 1,
    parameter int DEPTH      = 64
) (
    input  logic                    clk,
    input  logic                    areset,
    output logic                    axis_i_tready,
    input  logic                    axis_i_tvalid,
    input  logic                    axis_i_tlast,
    input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
    input  logic                    axis_o_tready,
    output logic                    axis_o_tvalid,
    output logic                    axis_o_tlast,
    output logic [8*AXIS_BYTES-1:0] axis_o_tdata,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    drain
);

    localparam int DW = 8 * AXIS_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int WW = word_width(AXIS_BYTES);
    localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("axis_packet_fifo: DEPTH must be a power of two and at least 4");
    end

    typedef struct packed {
        logic          tlast;
        logic [DW-1:0] tdata;
    } word_t;

    logic [PW-1:0] wr_ptr, rd_ptr, raddr_ptr, commit_ptr;
    logic [PW-1:0] wr_ptr_next, rd_ptr_next, rd_limit, pkt_next;
    logic          in_ready;
    logic          wr_fire, pop, ren, ram_valid, tail_seen;
    logic          pkt_inc, pkt_dec;
    logic [1:0]    out_cnt, out_cnt_after, level;
    logic [WW-1:0] ram_rdata;
    word_t         wr_word, ram_word, head_q, tail_q;
    fifo_state_t   state, state_next;

    assign wr_word  = '{tlast: axis_i_tlast, tdata: axis_i_tdata};
    assign ram_word = ram_rdata;

    sdp_ram #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .wen   (wr_fire),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_word),
        .ren   (ren),
        .raddr (raddr_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign axis_i_tready = in_ready;
    assign axis_o_tvalid = (out_cnt != 2'd0);
    assign axis_o_tlast  = head_q.tlast;
    assign axis_o_tdata  = head_q.tdata;
    assign drain         = (state == DRAIN);

    assign wr_fire       = axis_i_tvalid && in_ready;
    assign pop           = axis_o_tvalid && axis_o_tready;
    assign wr_ptr_next   = wr_ptr + PW'(wr_fire);
    assign rd_ptr_next   = rd_ptr + PW'(pop);

    // Before the oversize packet's tlast arrives, everything written may be
    // read; afterwards reading stops at that tlast so the following packet
    // is once again held until it is complete.
    assign rd_limit      = (state == DRAIN && !tail_seen) ? wr_ptr : commit_ptr;

    // A RAM read lands in the skid one cycle later, so only issue when the
    // skid is guaranteed a free slot even if the consumer stalls.
    assign level         = out_cnt + {1'b0, ram_valid};
    assign out_cnt_after = out_cnt - {1'b0, pop};
    assign ren           = (raddr_ptr != rd_limit) &&
                           ((level <= 2'd1) || ((level == 2'd2) && pop));

    // The oversize packet's own tlast is neither counted in nor counted out.
    assign pkt_inc  = wr_fire && axis_i_tlast && !(state == DRAIN && !tail_seen);
    assign pkt_dec  = pop && head_q.tlast && (state != DRAIN);
    assign pkt_next = pkt_count + PW'(pkt_inc) - PW'(pkt_dec);

    // Pointer, packet-count and input-ready registers. Ready uses the old
    // rd_ptr, so a pop frees space one cycle later but a write can never
    // overrun.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            raddr_ptr  <= '0;
            commit_ptr <= '0;
            pkt_count  <= '0;
            in_ready   <= 1'b0;
            ram_valid  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            pkt_count <= pkt_next;
            in_ready  <= ((wr_ptr_next - rd_ptr) != FULL_OCC);
            ram_valid <= ren;
            if (ren) begin
                raddr_ptr <= raddr_ptr + PW'(1);
            end
            if (wr_fire && axis_i_tlast) begin
                commit_ptr <= wr_ptr_next;
            end
        end
    end

    // Two-entry output skid: head drives the master port, tail absorbs the
    // beat already in flight from the RAM when the consumer stalls.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            head_q  <= '0;
            tail_q  <= '0;
            out_cnt <= 2'd0;
        end else begin
            if (pop) begin
                head_q <= tail_q;
            end
            if (ram_valid) begin
                if (out_cnt_after == 2'd0) begin
                    head_q <= ram_word;
                end else begin
                    tail_q <= ram_word;
                end
            end
            out_cnt <= out_cnt_after + {1'b0, ram_valid};
        end
    end

    // Drain state register and the flag marking that the oversize tail is stored.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= NORMAL;
            tail_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DRAIN && state_next == NORMAL) begin
                tail_seen <= 1'b0;
            end else if (state == DRAIN && wr_fire && axis_i_tlast) begin
                tail_seen <= 1'b1;
            end
        end
    end

    // Enter drain when the buffer will be full with no complete packet in it;
    // leave when the oversize tail pops.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL: begin
                if (((wr_ptr_next - rd_ptr_next) == FULL_OCC) && (pkt_next == '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_q.tlast) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

endmodule
